// File: rtl/rsb_spec_ctrl_if.sv
// Fetch/retire and RSB-side signal bundle for the RSB speculation controller.
// The controller takes the slave view; fetch, retire and the RSB sit on the master view.
interface rsb_spec_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  call_i;
    logic                  ret_i;
    logic [ADDR_WIDTH-1:0] call_addr_i;
    logic                  fetch_ready_o;
    logic                  pred_valid_o;
    logic [ADDR_WIDTH-1:0] pred_addr_o;
    logic                  retire_i;
    logic                  flush_i;
    logic                  busy_o;
    logic                  rsb_push_en_o;
    logic [ADDR_WIDTH-1:0] rsb_push_addr_o;
    logic                  rsb_pop_en_o;
    logic [ADDR_WIDTH-1:0] rsb_pop_addr_i;
    logic                  rsb_pop_valid_i;

    modport slave (
        input  call_i, ret_i, call_addr_i, retire_i, flush_i,
        input  rsb_pop_addr_i, rsb_pop_valid_i,
        output fetch_ready_o, pred_valid_o, pred_addr_o, busy_o,
        output rsb_push_en_o, rsb_push_addr_o, rsb_pop_en_o
    );

    modport master (
        output call_i, ret_i, call_addr_i, retire_i, flush_i,
        output rsb_pop_addr_i, rsb_pop_valid_i,
        input  fetch_ready_o, pred_valid_o, pred_addr_o, busy_o,
        input  rsb_push_en_o, rsb_push_addr_o, rsb_pop_en_o
    );
endinterface

// File: rtl/rsb_spec_ctrl.sv
// Speculation controller for the return stack buffer: logs every accepted
// call/return, retires oldest-first and unwinds newest-first on flush.
module rsb_spec_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int STACK_DEPTH = 16,
    parameter int LOG_DEPTH   = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    rsb_spec_ctrl_if.slave     bus
);
    localparam int PW = $clog2(LOG_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = (STACK_DEPTH > 0) ? $clog2(STACK_DEPTH + 1) : 1;
    localparam logic [OW-1:0] SD = OW'(STACK_DEPTH);
    localparam logic [CW-1:0] LD = CW'(LOG_DEPTH);

    typedef enum logic [1:0] {
        K_NOP,
        K_PUSH,
        K_POP,
        K_REPL
    } kind_t;

    typedef enum logic {
        IDLE,
        UNWIND
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [OW-1:0]         occ_q, occ_d;

    kind_t                 kind_mem [LOG_DEPTH];
    logic [ADDR_WIDTH-1:0] top_mem  [LOG_DEPTH];

    logic                  accept;
    logic                  retire_ok;
    logic                  wr_en;
    kind_t                 new_kind;
    logic [PW-1:0]         last;
    kind_t                 undo_kind;
    logic [ADDR_WIDTH-1:0] undo_top;

    assign last      = tail_q - PW'(1);
    assign undo_kind = kind_mem[last];
    assign undo_top  = top_mem[last];

    // Accept/retire/unwind decisions and combinational RSB drive
    always_comb begin
        state_d             = state_q;
        head_d              = head_q;
        tail_d              = tail_q;
        cnt_d               = cnt_q;
        occ_d               = occ_q;
        new_kind            = K_NOP;
        accept              = 1'b0;
        retire_ok           = 1'b0;
        wr_en               = 1'b0;
        bus.fetch_ready_o   = 1'b0;
        bus.pred_valid_o    = 1'b0;
        bus.pred_addr_o     = '0;
        bus.busy_o          = 1'b0;
        bus.rsb_push_en_o   = 1'b0;
        bus.rsb_push_addr_o = '0;
        bus.rsb_pop_en_o    = 1'b0;

        unique case (1'b1)
            bus.call_i && !bus.ret_i:
                new_kind = (occ_q < SD) ? K_PUSH : K_NOP;
            !bus.call_i && bus.ret_i:
                new_kind = (occ_q != '0) ? K_POP : K_NOP;
            bus.call_i && bus.ret_i:
                new_kind = (occ_q != '0) ? K_REPL
                         : ((occ_q < SD) ? K_PUSH : K_NOP);
            default:
                new_kind = K_NOP;
        endcase

        unique case (state_q)
            IDLE: begin
                bus.fetch_ready_o = (cnt_q != LD) && !bus.flush_i;
                accept    = (bus.call_i || bus.ret_i) && bus.fetch_ready_o;
                retire_ok = bus.retire_i && (cnt_q != '0);
                if (accept) begin
                    wr_en             = 1'b1;
                    tail_d            = tail_q + PW'(1);
                    bus.rsb_push_en_o = (new_kind == K_PUSH) || (new_kind == K_REPL);
                    bus.rsb_pop_en_o  = (new_kind == K_POP) || (new_kind == K_REPL);
                    if (bus.rsb_push_en_o)
                        bus.rsb_push_addr_o = bus.call_addr_i;
                    bus.pred_valid_o  = bus.ret_i && bus.rsb_pop_valid_i;
                    if (bus.pred_valid_o)
                        bus.pred_addr_o = bus.rsb_pop_addr_i;
                    if (new_kind == K_PUSH)
                        occ_d = occ_q + OW'(1);
                    else if (new_kind == K_POP)
                        occ_d = occ_q - OW'(1);
                end
                if (retire_ok)
                    head_d = head_q + PW'(1);
                cnt_d = cnt_q + CW'(accept) - CW'(retire_ok);
                // accept is blocked under flush, so cnt_d is the post-retire count
                if (bus.flush_i && (cnt_d != '0))
                    state_d = UNWIND;
            end
            UNWIND: begin
                bus.busy_o = 1'b1;
                case (undo_kind)
                    K_PUSH: begin
                        bus.rsb_pop_en_o = 1'b1;
                        occ_d            = occ_q - OW'(1);
                    end
                    K_POP: begin
                        bus.rsb_push_en_o   = 1'b1;
                        bus.rsb_push_addr_o = undo_top;
                        occ_d               = occ_q + OW'(1);
                    end
                    K_REPL: begin
                        bus.rsb_push_en_o   = 1'b1;
                        bus.rsb_pop_en_o    = 1'b1;
                        bus.rsb_push_addr_o = undo_top;
                    end
                    default: ;
                endcase
                tail_d = last;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointers, log count and RSB occupancy mirror
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            occ_q   <= occ_d;
        end
    end

    // Log payload; validity is tracked by the pointers alone
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            kind_mem[tail_q] <= new_kind;
            top_mem[tail_q]  <= bus.rsb_pop_addr_i;
        end
    end

    // Retiring while an unwind is running breaks the log ordering
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == UNWIND) |-> !bus.retire_i);
endmodule

// File: tb/tb_rsb_spec_ctrl.sv
// Directed bench for rsb_spec_ctrl with a small behavioural RSB
// attached to its push/pop ports.
module tb_rsb_spec_ctrl;
    localparam int AW = 16;
    localparam int SD = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   n;

    rsb_spec_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    rsb_spec_ctrl #(
        .ADDR_WIDTH (AW),
        .STACK_DEPTH(SD),
        .LOG_DEPTH  (8)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    // Behavioural return stack buffer
    logic [AW-1:0] stk [SD];
    int            rcnt;

    always @(posedge clk) begin
        if (!rst_n) begin
            rcnt <= 0;
        end else if (bus.rsb_push_en_o && bus.rsb_pop_en_o) begin
            if (rcnt > 0) stk[rcnt-1] <= bus.rsb_push_addr_o;
        end else if (bus.rsb_push_en_o) begin
            if (rcnt < SD) begin
                stk[rcnt] <= bus.rsb_push_addr_o;
                rcnt      <= rcnt + 1;
            end
        end else if (bus.rsb_pop_en_o) begin
            if (rcnt > 0) rcnt <= rcnt - 1;
        end
    end

    assign bus.rsb_pop_valid_i = (rcnt > 0);
    assign bus.rsb_pop_addr_i  = (rcnt > 0) ? stk[rcnt-1] : '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        bus.call_i      = 1'b0;
        bus.ret_i       = 1'b0;
        bus.call_addr_i = '0;
        bus.retire_i    = 1'b0;
        bus.flush_i     = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle_in();
        #1;
    endtask

    task automatic drive(input logic c, input logic r, input logic [AW-1:0] a,
                         input logic rt, input logic fl);
        bus.call_i      = c;
        bus.ret_i       = r;
        bus.call_addr_i = a;
        bus.retire_i    = rt;
        bus.flush_i     = fl;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_in();
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic run_unwind(output int cycles);
        cycles = 0;
        while (bus.busy_o && cycles < 20) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle_in();

        // reset state
        do_reset();
        chk("rst_fetch_ready", bus.fetch_ready_o, 1);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_push_en", bus.rsb_push_en_o, 0);
        chk("rst_pop_en", bus.rsb_pop_en_o, 0);
        chk("rst_pred_valid", bus.pred_valid_o, 0);
        chk("rst_pred_addr", bus.pred_addr_o, 0);
        chk("rst_push_addr", bus.rsb_push_addr_o, 0);

        // T1: two calls then a predicted return
        drive(1, 0, 16'h100, 0, 0);
        chk("t1_push_en0", bus.rsb_push_en_o, 1);
        chk("t1_push_addr0", bus.rsb_push_addr_o, 16'h100);
        tick();
        drive(1, 0, 16'h200, 0, 0);
        chk("t1_push_en1", bus.rsb_push_en_o, 1);
        chk("t1_push_addr1", bus.rsb_push_addr_o, 16'h200);
        tick();
        drive(0, 1, 16'h0, 0, 0);
        chk("t1_pred_valid", bus.pred_valid_o, 1);
        chk("t1_pred_addr", bus.pred_addr_o, 16'h200);
        chk("t1_pop_en", bus.rsb_pop_en_o, 1);
        chk("t1_push_en2", bus.rsb_push_en_o, 0);
        tick();
        chk("t1_rsb_top", bus.rsb_pop_addr_i, 16'h100);

        // T2: committed calls, speculative call/ret/ret, flush unwind
        do_reset();
        drive(1, 0, 16'h10, 0, 0); tick();
        drive(1, 0, 16'h20, 0, 0); tick();
        drive(0, 0, 16'h0, 1, 0); tick();
        drive(0, 0, 16'h0, 1, 0); tick();
        drive(1, 0, 16'h30, 0, 0); tick();
        drive(0, 1, 16'h0, 0, 0);
        chk("t2_pred_addr0", bus.pred_addr_o, 16'h30);
        tick();
        drive(0, 1, 16'h0, 0, 0);
        chk("t2_pred_addr1", bus.pred_addr_o, 16'h20);
        tick();
        drive(0, 0, 16'h0, 0, 1);
        chk("t2_flush_ready", bus.fetch_ready_o, 0);
        tick();
        chk("t2_u1_busy", bus.busy_o, 1);
        chk("t2_u1_ready", bus.fetch_ready_o, 0);
        chk("t2_u1_push", bus.rsb_push_en_o, 1);
        chk("t2_u1_addr", bus.rsb_push_addr_o, 16'h20);
        chk("t2_u1_pop", bus.rsb_pop_en_o, 0);
        tick();
        chk("t2_u2_push", bus.rsb_push_en_o, 1);
        chk("t2_u2_addr", bus.rsb_push_addr_o, 16'h30);
        tick();
        chk("t2_u3_pop", bus.rsb_pop_en_o, 1);
        chk("t2_u3_push", bus.rsb_push_en_o, 0);
        chk("t2_u3_busy", bus.busy_o, 1);
        tick();
        chk("t2_done_busy", bus.busy_o, 0);
        chk("t2_done_ready", bus.fetch_ready_o, 1);
        chk("t2_top", bus.rsb_pop_addr_i, 16'h20);
        chk("t2_occ", rcnt, 2);
        drive(0, 0, 16'h0, 0, 1);
        tick();
        chk("t2_empty_flush_busy", bus.busy_o, 0);

        // T3: overflow becomes a NOP, return on empty stack
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(1, 0, AW'(i), 0, 0);
            chk("t3_push_en", bus.rsb_push_en_o, 1);
            tick();
        end
        drive(1, 0, 16'h5, 0, 0);
        chk("t3_full_ready", bus.fetch_ready_o, 1);
        chk("t3_full_push_en", bus.rsb_push_en_o, 0);
        tick();
        drive(0, 0, 16'h0, 0, 1);
        tick();
        chk("t3_nop_undo_push", bus.rsb_push_en_o, 0);
        chk("t3_nop_undo_pop", bus.rsb_pop_en_o, 0);
        chk("t3_nop_undo_busy", bus.busy_o, 1);
        run_unwind(n);
        chk("t3_unwind_cycles", n, 5);
        chk("t3_occ_after", rcnt, 0);
        drive(0, 1, 16'h0, 0, 0);
        chk("t3_empty_pred", bus.pred_valid_o, 0);
        chk("t3_empty_pop", bus.rsb_pop_en_o, 0);
        chk("t3_empty_ready", bus.fetch_ready_o, 1);
        tick();

        // T4: replace on call+ret, undone by flush
        do_reset();
        drive(1, 0, 16'hA0, 0, 0); tick();
        drive(0, 0, 16'h0, 1, 0); tick();
        drive(1, 1, 16'hB0, 0, 0);
        chk("t4_push", bus.rsb_push_en_o, 1);
        chk("t4_pop", bus.rsb_pop_en_o, 1);
        chk("t4_push_addr", bus.rsb_push_addr_o, 16'hB0);
        chk("t4_pred_valid", bus.pred_valid_o, 1);
        chk("t4_pred_addr", bus.pred_addr_o, 16'hA0);
        tick();
        chk("t4_top_repl", bus.rsb_pop_addr_i, 16'hB0);
        drive(0, 0, 16'h0, 0, 1); tick();
        chk("t4_undo_push", bus.rsb_push_en_o, 1);
        chk("t4_undo_pop", bus.rsb_pop_en_o, 1);
        chk("t4_undo_addr", bus.rsb_push_addr_o, 16'hA0);
        tick();
        chk("t4_top_restored", bus.rsb_pop_addr_i, 16'hA0);
        chk("t4_occ", rcnt, 1);
        chk("t4_busy", bus.busy_o, 0);

        // T5: full log, retire+accept, pointer wrap, long unwind
        do_reset();
        drive(1, 0, 16'h1, 0, 0); tick();
        drive(1, 0, 16'h2, 0, 0); tick();
        drive(0, 0, 16'h0, 1, 0); tick();
        drive(0, 0, 16'h0, 1, 0); tick();
        drive(1, 0, 16'h3, 0, 0); tick();
        drive(1, 0, 16'h4, 0, 0); tick();
        drive(1, 0, 16'h5, 0, 0); tick();
        drive(0, 1, 16'h0, 0, 0); tick();
        drive(0, 1, 16'h0, 0, 0); tick();
        drive(1, 0, 16'h6, 0, 0); tick();
        drive(1, 0, 16'h7, 0, 0); tick();
        drive(0, 1, 16'h0, 0, 0); tick();
        drive(1, 0, 16'h99, 0, 0);
        chk("t5_full_ready", bus.fetch_ready_o, 0);
        chk("t5_full_push", bus.rsb_push_en_o, 0);
        tick();
        drive(0, 0, 16'h0, 1, 0); tick();
        drive(1, 0, 16'h8, 1, 0);
        chk("t5_rr_ready", bus.fetch_ready_o, 1);
        chk("t5_rr_push", bus.rsb_push_en_o, 1);
        chk("t5_rr_addr", bus.rsb_push_addr_o, 16'h8);
        tick();
        drive(1, 0, 16'h9, 0, 0);
        chk("t5_last_ready", bus.fetch_ready_o, 1);
        chk("t5_last_nop", bus.rsb_push_en_o, 0);
        tick();
        chk("t5_refull_ready", bus.fetch_ready_o, 0);
        drive(0, 0, 16'h0, 0, 1); tick();
        chk("t5_u1_push", bus.rsb_push_en_o, 0);
        chk("t5_u1_pop", bus.rsb_pop_en_o, 0);
        run_unwind(n);
        chk("t5_unwind_cycles", n, 8);
        chk("t5_occ", rcnt, 4);
        chk("t5_top", bus.rsb_pop_addr_i, 16'h4);
        chk("t5_ready", bus.fetch_ready_o, 1);

        // T6: reset while unwinding
        do_reset();
        drive(1, 0, 16'h11, 0, 0); tick();
        drive(1, 0, 16'h22, 0, 0); tick();
        drive(0, 0, 16'h0, 0, 1); tick();
        chk("t6_busy_before", bus.busy_o, 1);
        rst_n = 1'b0;
        tick();
        chk("t6_busy", bus.busy_o, 0);
        chk("t6_push", bus.rsb_push_en_o, 0);
        chk("t6_pop", bus.rsb_pop_en_o, 0);
        chk("t6_ready", bus.fetch_ready_o, 1);
        rst_n = 1'b1;
        #1;
        drive(0, 0, 16'h0, 0, 1); tick();
        chk("t6_log_empty", bus.busy_o, 0);
        chk("t6_occ", rcnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
